// File: rtl/fxp_accum_pkg.sv
// Shared types and width helpers for the fixed-point block accumulator.
package fxp_accum_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Counter must hold the value N_SAMPLES itself, hence n+1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_point_accum_if.sv
// Sample input and block-sum output channels of the fixed-point accumulator.
interface fixed_point_accum_if #(
  parameter int I_P     = 4,
  parameter int F_P     = 4,
  parameter int ACC_I_P = 8
);
  localparam int SW = I_P + F_P;
  localparam int W  = ACC_I_P + F_P;

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the source holds payload stable while valid is high and ready is low.
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic          in_ovf;
  logic          in_unf;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          out_unf;

  modport master (
    output in_valid, in_data, in_ovf, in_unf, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_data, in_ovf, in_unf, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_unf
  );
endinterface

// File: rtl/fxp_sat_add.sv
// W-bit signed adder with overflow flag; saturates when FXP_ACCUM_SAT_EN is
// defined, otherwise wraps modulo 2^W.
module fxp_sat_add
  import fxp_accum_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] sum_ext;

  assign sum_ext = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign ovf_o   = sum_ext[W] ^ sum_ext[W-1];

`ifdef FXP_ACCUM_SAT_EN
  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  // The true sign of the result is bit W; it picks the rail to clamp to.
  always_comb begin
    sum_o = sum_ext[W-1:0];
    if (ovf_o) begin
      sum_o = sum_ext[W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum_o = sum_ext[W-1:0];
`endif

endmodule

// File: rtl/fixed_point_accum.sv
// Accumulates N_SAMPLES signed fixed-point samples into one block sum with
// sticky overflow/underflow flags. Optional macro: FXP_ACCUM_SAT_EN.
module fixed_point_accum
  import fxp_accum_pkg::*;
#(
  parameter int I_P       = 4,
  parameter int F_P       = 4,
  parameter int ACC_I_P   = 8,
  parameter int N_SAMPLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  fixed_point_accum_if.slave  bus,
  output state_e              dbg_state_o
);

  localparam int SW = I_P + F_P;
  localparam int W  = ACC_I_P + F_P;
  localparam int CW = cnt_width(N_SAMPLES);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic [SW-1:0]  sample;
  logic [W-1:0]   sample_ext;
  logic [W-1:0]   add_sum;
  logic           add_ovf;
  logic           accept;

  assign sample     = bus.in_data;
  assign sample_ext = W'($signed(sample));
  assign accept     = bus.in_valid && (state_q == ST_ACCUM);

  fxp_sat_add #(.W(W)) u_add (
    .a_i   (acc_q),
    .b_i   (sample_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // clear outranks both an accept and an output handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | bus.in_ovf | add_ovf;
            unf_d = unf_q | bus.in_unf;
            if (cnt_q == CW'(N_SAMPLES - 1)) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_unf   = unf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fixed_point_accum.sv
// Directed plus random block tests for fixed_point_accum (W = 9, 4 samples).
module tb_fixed_point_accum;
  import fxp_accum_pkg::*;

  localparam int I_P = 4;
  localparam int F_P = 4;
  localparam int ACC_I_P = 5;
  localparam int N = 4;
  localparam int W = ACC_I_P + F_P;
  localparam logic [W-1:0] MAXV = 9'h0FF;
  localparam logic [W-1:0] MINV = 9'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  state_e dbg_state;

  int chk_cnt = 0;
  int pass_cnt = 0;
  // entries are {ovf, unf, data}
  logic [W+1:0] exp_q[$];

  fixed_point_accum_if #(.I_P(I_P), .F_P(F_P), .ACC_I_P(ACC_I_P)) bus ();

  fixed_point_accum #(.I_P(I_P), .F_P(F_P), .ACC_I_P(ACC_I_P), .N_SAMPLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic fail_now(input string tag);
    chk_cnt++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic send(input logic [7:0] d, input logic o, input logic u);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_ovf = o;
    bus.in_unf = u;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_ovf = 1'b0;
    bus.in_unf = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now({tag, "_timeout"});
  endtask

  task automatic recv(input string tag);
    logic [W+1:0] e;
    wait_valid(tag);
    if (exp_q.size() == 0) begin
      fail_now({tag, "_empty_queue"});
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(bus.out_data), 32'(e[W-1:0]));
      chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e[W+1]));
      chk({tag, "_unf"}, 32'(bus.out_unf), 32'(e[W]));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic block4(input logic [7:0] d);
    for (int i = 0; i < N; i++) send(d, 1'b0, 1'b0);
  endtask

  // Independent reference for one accumulate step; returns {ovf, sum}.
  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [7:0] s);
    logic [W:0] t;
    logic ov;
    logic [W-1:0] r;
    t = {a[W-1], a} + {{2{s[7]}}, s};
    ov = t[W] ^ t[W-1];
    r = t[W-1:0];
`ifdef FXP_ACCUM_SAT_EN
    if (ov) r = t[W] ? MINV : MAXV;
`endif
    return {ov, r};
  endfunction

  initial begin
    logic [W-1:0] m_acc;
    logic m_ovf, m_unf;
    logic [W:0] step;
    logic [7:0] d;
    logic o, u;

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_ovf = 1'b0;
    bus.in_unf = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_out_unf", 32'(bus.out_unf), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_ACCUM));

    // Basic block and one-cycle output latency
    for (int i = 0; i < 3; i++) send(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_pre_valid", 32'(bus.out_valid), 32'd0);
    send(8'h10, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 9'h040});
    @(negedge clk);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_in_ready", 32'(bus.in_ready), 32'd0);
    recv("basic");

    // Positive overflow
    block4(8'h7F);
`ifdef FXP_ACCUM_SAT_EN
    exp_q.push_back({1'b1, 1'b0, 9'h0FF});
`else
    exp_q.push_back({1'b1, 1'b0, 9'h1FC});
`endif
    recv("pos_ovf");

    // Negative overflow
    block4(8'h80);
`ifdef FXP_ACCUM_SAT_EN
    exp_q.push_back({1'b1, 1'b0, 9'h100});
`else
    exp_q.push_back({1'b1, 1'b0, 9'h000});
`endif
    recv("neg_ovf");

    // Output stall with a sample offered meanwhile
    send(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h10, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 9'h040});
    wait_valid("stall");
    bus.in_valid = 1'b1;
    bus.in_data = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'h040);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    recv("stall");
    block4(8'h01);
    exp_q.push_back({1'b0, 1'b0, 9'h004});
    recv("after_stall");

    // clear mid-block alongside a valid sample
    send(8'h10, 1'b0, 1'b1);
    send(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h10;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_acc", 32'(bus.out_data), 32'd0);
    chk("clr_unf", 32'(bus.out_unf), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("clr_no_out", 32'(bus.out_valid), 32'd0);
    block4(8'h20);
    exp_q.push_back({1'b0, 1'b0, 9'h080});
    recv("after_clr");

    // clear in HOLD together with out_ready
    send(8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h10, 1'b0, 1'b0);
    wait_valid("hold_clr");
    clear = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("hold_clr_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_clr_data", 32'(bus.out_data), 32'd0);
    chk("hold_clr_ovf", 32'(bus.out_ovf), 32'd0);
    chk("hold_clr_unf", 32'(bus.out_unf), 32'd0);

    // Async reset mid-block
    send(8'h10, 1'b1, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    block4(8'h10);
    exp_q.push_back({1'b0, 1'b0, 9'h040});
    recv("after_rst");

    // Random blocks against the reference model
    for (int b = 0; b < 4; b++) begin
      m_acc = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < N; i++) begin
        d = 8'($urandom_range(0, 255));
        o = ($urandom_range(0, 7) == 0);
        u = ($urandom_range(0, 7) == 0);
        step = model_add(m_acc, d);
        m_acc = step[W-1:0];
        m_ovf = m_ovf | o | step[W];
        m_unf = m_unf | u;
        send(d, o, u);
      end
      exp_q.push_back({m_ovf, m_unf, m_acc});
      recv("rand");
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fixed_point_accum.md
FIXED_POINT_ACCUM -- requirements
Module: fixed_point_accum

Interface
REQ-001 Parameter I_P, default 4, integer bits of the incoming signed sample (adder result format).
REQ-002 Parameter F_P, default 4, fractional bits of the sample and of the accumulator.
REQ-003 Parameter ACC_I_P, default 8, accumulator integer bits; ACC_I_P >= I_P is required.
REQ-004 Parameter N_SAMPLES, default 8, samples per block; N_SAMPLES >= 2 is required.
REQ-005 Ports, in order: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 clear  input  1  synchronous block abort.
REQ-009 in_valid  input  1  sample present.
REQ-010 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-011 in_data  input  I_P+F_P  signed two's-complement sample.
REQ-012 in_ovf  input  1  upstream adder overflow flag for this sample.
REQ-013 in_unf  input  1  upstream adder underflow flag for this sample.
REQ-014 out_valid  output  1  block sum available.
REQ-015 out_ready  input  1  consumer takes the sum when out_valid && out_ready.
REQ-016 out_data  output  ACC_I_P+F_P  signed block sum, same F_P.
REQ-017 out_ovf  output  1  sticky: any in_ovf or accumulator saturation/wrap in the block.
REQ-018 out_unf  output  1  sticky: any in_unf in the block.

Function
REQ-019 Two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-020 In ACCUM, each accepted sample is sign-extended to W=ACC_I_P+F_P bits and added to the accumulator in W+1 bits.
REQ-021 Overflow of an add is detected when bit W and bit W-1 of the W+1-bit sum differ.
REQ-022 The sample counter increments per accepted sample; the accept that makes the count equal to N_SAMPLES moves to HOLD at the next edge.
REQ-023 out_valid rises the cycle after the N-th accepted sample; out_data, out_ovf and out_unf include that sample.
REQ-024 In HOLD, out_data/out_ovf/out_unf are stable until handshake; in_valid is ignored.
REQ-025 On out_valid && out_ready: return to ACCUM with accumulator, counter and sticky flags zeroed; in_ready is high in the next cycle, giving no back-to-back accept.
REQ-026 clear has priority over all events, including a simultaneous accept or output handshake: next state ACCUM, accumulator, counter and flags zeroed, and the sample presented that cycle is dropped.
REQ-027 Flags accumulate as OR-sticky across a block and clear only on handshake, clear or rst.

Reset
REQ-028 rst asserted at any time, including mid-block or in HOLD, forces ACCUM with accumulator=0, counter=0, out_valid=0, out_data=0, out_ovf=0, out_unf=0 and in_ready=1 after release.

Configuration
REQ-029 Macro FXP_ACCUM_SAT_EN defined: an overflowing add saturates to max {0,1...1} or min {1,0...0}, and out_ovf is set.
REQ-030 Macro FXP_ACCUM_SAT_EN undefined: an overflowing add wraps modulo 2^W and out_ovf is still set.

Structure
REQ-031 Package fxp_accum_pkg holds the state enum, W-derived saturation max/min constant functions and counter width via $clog2(N_SAMPLES+1).
REQ-032 One sub-module, fxp_sat_add, is a W-bit signed adder with overflow output and saturation gated by FXP_ACCUM_SAT_EN.

Verification (I_P=4, F_P=4, ACC_I_P=5, N_SAMPLES=4, W=9)
REQ-033 Four samples of 8'h10, out_ready=1 -> out_data=9'h040, out_ovf=0, out_unf=0, out_valid high one cycle after the 4th accept.
REQ-034 Four samples of 8'h7F -> with FXP_ACCUM_SAT_EN, out_data=9'h0FF and out_ovf=1; without it, out_data=9'h1FC and out_ovf=1.
REQ-035 Four samples of 8'h80 with FXP_ACCUM_SAT_EN -> out_data=9'h100 and out_ovf=1.
REQ-036 Block sum ready with out_ready held low 3 cycles -> out_valid and out_data stable, in_ready=0, and a sample offered during the stall is not counted.
REQ-037 Samples 8'h10 with in_unf=1, 8'h10, then clear in the 3rd cycle alongside a valid sample -> no output; the next 4 samples of 8'h20 give out_data=9'h080 and out_unf=0.
REQ-038 rst pulsed after 2 accepts, then 4 samples of 8'h10 -> out_data=9'h040, with no residue from the earlier samples.
